// File: rtl/booth_mult_unit_pkg.sv
// Shared definitions for the Booth multiplier: operand width and FSM state encoding.
package booth_mult_unit_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/booth_mult_unit_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// followed by an arithmetic right shift of {A, Q, Q_1}.
module booth_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH:0] sum;

    // Select A+M, A-M or A from the Booth pair, then shift the whole triple right.
    always_comb begin
        sum = acc;
        unique case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_next = {sum[WIDTH], sum[WIDTH:1]};
        q_next   = {sum[0], q[WIDTH-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_mult_unit.sv
// Multicycle signed multiplier for MULT: one Booth step per clock,
// start/busy/done handshake, product held in hi/lo until the next completion.
module booth_mult_unit
    import booth_mult_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic [WIDTH-1:0] mult_a,
    input  logic [WIDTH-1:0] mult_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_busy,
    output logic             mult_done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mult_state_t state, state_next;

    logic [WIDTH:0]   acc, m, acc_n;
    logic [WIDTH-1:0] q, q_n;
    logic             q_1, q_1_n;
    logic [CW-1:0]    count;
    logic             accept, last_step;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .acc_next (acc_n),
        .q_next   (q_n),
        .q_1_next (q_1_n)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mult_start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (count == LAST_STEP) begin
                    last_step  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: load operands on accept, iterate while running, publish on the last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            m     <= {mult_a[WIDTH-1], mult_a};
            acc   <= '0;
            q     <= mult_b;
            q_1   <= 1'b0;
            count <= '0;
        end else if (state == ST_RUN) begin
            acc   <= acc_n;
            q     <= q_n;
            q_1   <= q_1_n;
            count <= count + 1'b1;
            if (last_step) begin
                hi <= acc_n[WIDTH-1:0];
                lo <= q_n;
            end
        end
    end

    // busy/done are decoded from the registered state, so they are glitch-free
    // and change exactly on the accepting/completing edges.
    assign mult_busy = (state == ST_RUN);
    assign mult_done = (state == ST_DONE);

endmodule
